lcd_write_controller: RTL



---
 rtl/lcd_write_controller_if.sv | 25 ++
 rtl/lcd_write_controller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_write_controller_if.sv
// CPU-side request/busy handshake of the character-LCD write controller.
// The CPU datapath is the master; lcd_write_controller is the slave.
interface lcd_write_controller_if;
    logic       iInit;
    logic       iWrite;
    logic       iRS;
    logic [7:0] iData;
    logic       oBusy;

    modport master (
        output iInit,
        output iWrite,
        output iRS,
        output iData,
        input  oBusy
    );

    modport slave (
        input  iInit,
        input  iWrite,
        input  iRS,
        input  iData,
        output oBusy
    );
endinterface

// File: rtl/lcd_write_controller.sv
// HD44780 4-bit power-up sequencer and CPU write responder for the Spartan-3E LCD.
// Define LCD_BYTE_MODE_EN to send a full byte (two nibbles) per write; by default only iData[7:4] is sent.
module lcd_write_controller #(
    parameter int unsigned POWERUP_CYCLES = 750000,
    parameter int unsigned INIT_WAIT1     = 205000,
    parameter int unsigned INIT_WAIT2     = 5000,
    parameter int unsigned EXEC_CYCLES    = 2000,
    parameter int unsigned CLEAR_CYCLES   = 82000,
    parameter int unsigned SETUP_CYCLES   = 2,
    parameter int unsigned E_CYCLES       = 12,
    parameter int unsigned NIBBLE_GAP     = 50
) (
    input  logic                  Clock,
    input  logic                  Reset,
    lcd_write_controller_if.slave cpu,
    output logic                  oLCD_E,
    output logic                  oLCD_RS,
    output logic                  oLCD_RW,
    output logic [3:0]            oSF_D,
    output logic                  oSF_CE0
);

    typedef logic [19:0] cnt_t;

    // A state that must last N cycles loads N-1 on entry and leaves when the count hits zero.
    localparam cnt_t LD_POWERUP  = cnt_t'(POWERUP_CYCLES - 1);
    localparam cnt_t LD_WAIT1    = cnt_t'(INIT_WAIT1 - 1);
    localparam cnt_t LD_WAIT2    = cnt_t'(INIT_WAIT2 - 1);
    localparam cnt_t LD_EXEC     = cnt_t'(EXEC_CYCLES - 1);
    localparam cnt_t LD_SETUP    = cnt_t'(SETUP_CYCLES - 1);
    localparam cnt_t LD_PULSE    = cnt_t'(E_CYCLES - 1);
    // The first setup of a CPU write also absorbs the request-latch cycle.
    localparam cnt_t LD_SETUP_WR = cnt_t'(SETUP_CYCLES);
`ifdef LCD_BYTE_MODE_EN
    localparam cnt_t LD_CLEAR    = cnt_t'(CLEAR_CYCLES - 1);
    localparam cnt_t LD_GAP      = cnt_t'(NIBBLE_GAP - 1);
`else
    localparam int unsigned unused_byte_cfg = CLEAR_CYCLES + NIBBLE_GAP;
`endif

    typedef enum logic [3:0] {
        ST_POWERUP,
        ST_INIT_SETUP,
        ST_INIT_PULSE,
        ST_INIT_WAIT,
        ST_IDLE,
        ST_SETUP_HI,
        ST_PULSE_HI,
`ifdef LCD_BYTE_MODE_EN
        ST_GAP,
        ST_SETUP_LO,
        ST_PULSE_LO,
`endif
        ST_EXEC
    } state_t;

    state_t     state;
    cnt_t       cnt;
    logic [1:0] idx;
    logic       busy;
    logic       accept;

    function automatic cnt_t init_wait(input logic [1:0] n);
        case (n)
            2'd0:    init_wait = LD_WAIT1;
            2'd1:    init_wait = LD_WAIT2;
            default: init_wait = LD_EXEC;
        endcase
    endfunction

    // iInit has priority over a simultaneous iWrite.
    assign accept = (state == ST_IDLE) && !cpu.iInit && cpu.iWrite;

`ifdef LCD_BYTE_MODE_EN
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       wr_clear;

    always_ff @(posedge Clock) begin
        if (accept) begin
            wr_rs   <= cpu.iRS;
            wr_data <= cpu.iData;
        end
    end

    // Clear display / return home need the long execution wait.
    assign wr_clear = !wr_rs && ((wr_data == 8'h01) || (wr_data == 8'h02));
`else
    logic unused_low_nibble;
    assign unused_low_nibble = ^cpu.iData[3:0];
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state   <= ST_POWERUP;
            cnt     <= LD_POWERUP;
            idx     <= 2'd0;
            busy    <= 1'b1;
            oLCD_E  <= 1'b0;
            oLCD_RS <= 1'b0;
            oSF_D   <= 4'h0;
        end else if (state != ST_IDLE && cnt != '0) begin
            cnt <= cnt - 20'd1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu.iInit) begin
                        state   <= ST_INIT_SETUP;
                        cnt     <= LD_SETUP;
                        idx     <= 2'd0;
                        busy    <= 1'b1;
                        oLCD_RS <= 1'b0;
                        oSF_D   <= 4'h3;
                    end else if (accept) begin
                        state   <= ST_SETUP_HI;
                        cnt     <= LD_SETUP_WR;
                        busy    <= 1'b1;
                        oLCD_RS <= cpu.iRS;
                        oSF_D   <= cpu.iData[7:4];
                    end
                end
                ST_POWERUP: begin
                    state   <= ST_INIT_SETUP;
                    cnt     <= LD_SETUP;
                    idx     <= 2'd0;
                    oLCD_RS <= 1'b0;
                    oSF_D   <= 4'h3;
                end
                ST_INIT_SETUP: begin
                    state  <= ST_INIT_PULSE;
                    cnt    <= LD_PULSE;
                    oLCD_E <= 1'b1;
                end
                ST_INIT_PULSE: begin
                    state  <= ST_INIT_WAIT;
                    cnt    <= init_wait(idx);
                    oLCD_E <= 1'b0;
                end
                ST_INIT_WAIT: begin
                    if (idx == 2'd3) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= ST_INIT_SETUP;
                        cnt   <= LD_SETUP;
                        idx   <= idx + 2'd1;
                        // Init nibbles run 3, 3, 3 and finish with 2 to enter 4-bit mode.
                        oSF_D <= (idx == 2'd2) ? 4'h2 : 4'h3;
                    end
                end
                ST_SETUP_HI: begin
                    state  <= ST_PULSE_HI;
                    cnt    <= LD_PULSE;
                    oLCD_E <= 1'b1;
                end
`ifdef LCD_BYTE_MODE_EN
                ST_PULSE_HI: begin
                    state  <= ST_GAP;
                    cnt    <= LD_GAP;
                    oLCD_E <= 1'b0;
                end
                ST_GAP: begin
                    state <= ST_SETUP_LO;
                    cnt   <= LD_SETUP;
                    oSF_D <= wr_data[3:0];
                end
                ST_SETUP_LO: begin
                    state  <= ST_PULSE_LO;
                    cnt    <= LD_PULSE;
                    oLCD_E <= 1'b1;
                end
                ST_PULSE_LO: begin
                    state  <= ST_EXEC;
                    cnt    <= wr_clear ? LD_CLEAR : LD_EXEC;
                    oLCD_E <= 1'b0;
                end
`else
                ST_PULSE_HI: begin
                    state  <= ST_EXEC;
                    cnt    <= LD_EXEC;
                    oLCD_E <= 1'b0;
                end
`endif
                ST_EXEC: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state  <= ST_POWERUP;
                    cnt    <= LD_POWERUP;
                    busy   <= 1'b1;
                    oLCD_E <= 1'b0;
                end
            endcase
        end
    end

    assign cpu.oBusy = busy;
    assign oLCD_RW   = 1'b0;
    assign oSF_CE0   = 1'b1;

endmodule
